ex_mem_stage: RTL

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register built as a 2-entry FIFO skid buffer.
// Holds up to two EX results so the EX stage can keep issuing for one cycle
// after MEM stalls. It also holds the committed N/Z/V flag register and
// optionally forwards the head result back to the ID stage.
// Optional feature macro: EX_MEM_FWD_EN. When it is defined, the head result is
// forwarded to matching ID source registers. When it is undefined, the
// forwarding outputs are tied to zero.

module ex_mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_out,
  input  logic [4:0]  ex_dst,
  input  logic [31:0] ex_store_data,
  input  logic [2:0]  ex_ctrl,
  input  logic        ex_set_flags,
  input  logic        ex_n,
  input  logic        ex_z,
  input  logic        ex_v,
  input  logic        flush,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr_res,
  output logic [4:0]  mem_dst,
  output logic [31:0] mem_store_data,
  output logic [2:0]  mem_ctrl,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_v,
  input  logic [4:0]  src1,
  input  logic [4:0]  src2,
  output logic        fwd1_hit,
  output logic        fwd2_hit,
  output logic [31:0] fwd_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occState_e;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  dst;
    logic [31:0] storeData;
    logic [2:0]  ctrl;
  } entry_t;

  occState_e   state_q, state_d;
  entry_t      head_q, head_d;
  entry_t      tail_q, tail_d;
  logic        exReady_q, exReady_d;
  logic [2:0]  flags_q, flags_d;

  entry_t      incoming;
  logic        xferIn;
  logic        xferOut;

  assign incoming = {ex_out, ex_dst, ex_store_data, ex_ctrl};

  // A handshake only counts on the side whose ready/valid is genuinely high.
  assign xferIn    = ex_valid & exReady_q;
  assign mem_valid = (state_q != EMPTY);
  assign xferOut   = mem_valid & mem_ready;

  assign ex_ready       = exReady_q;
  assign mem_addr_res   = head_q.res;
  assign mem_dst        = head_q.dst;
  assign mem_store_data = head_q.storeData;
  assign mem_ctrl       = head_q.ctrl;
  assign flag_n         = flags_q[2];
  assign flag_z         = flags_q[1];
  assign flag_v         = flags_q[0];

  // Occupancy FSM and data movement. The head slot is always the oldest entry.
  // The tail slot is only meaningful in FULL. Flush wins over an incoming result.
  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    exReady_d = exReady_q;
    if (flush) begin
      state_d   = EMPTY;
      exReady_d = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (xferIn) begin
            head_d  = incoming;
            state_d = ONE;
          end
        end
        ONE: begin
          if (xferIn && xferOut) begin
            head_d = incoming;
          end else if (xferIn) begin
            tail_d    = incoming;
            state_d   = FULL;
            exReady_d = 1'b0;
          end else if (xferOut) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (xferOut) begin
            head_d    = tail_q;
            state_d   = ONE;
            exReady_d = 1'b1;
          end
        end
        default: begin
          state_d   = EMPTY;
          exReady_d = 1'b1;
        end
      endcase
    end
  end

  // Flags commit only with an accepted result. A flushed result never commits.
  always_comb begin
    flags_d = flags_q;
    if (xferIn && ex_set_flags && !flush) begin
      flags_d = {ex_n, ex_z, ex_v};
    end
  end

  // Register all state. A synchronous reset drops both entries and clears the flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      head_q    <= '0;
      tail_q    <= '0;
      exReady_q <= 1'b1;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      exReady_q <= exReady_d;
      flags_q   <= flags_d;
    end
  end

`ifdef EX_MEM_FWD_EN
  logic headFwdable;

  // A head entry can forward only when it writes a real register with an ALU
  // result. A load's value is not known yet, and r0 is never forwarded.
  assign headFwdable = mem_valid && head_q.ctrl[2] && !head_q.ctrl[1] &&
                       (head_q.dst != 5'd0);
  assign fwd1_hit    = headFwdable && (head_q.dst == src1);
  assign fwd2_hit    = headFwdable && (head_q.dst == src2);
  assign fwd_data    = head_q.res;
`else
  logic unusedSrc;

  assign unusedSrc = ^{src1, src2};
  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd_data  = 32'd0;
`endif

  // The registered ready must always agree with the occupancy state.
  readyMatchesState: assert property (@(posedge clk) disable iff (!rst_n)
    exReady_q == (state_q != FULL));

  // A stalled head entry must not change under MEM.
  headStableWhileStalled: assert property (@(posedge clk)
    (rst_n && !flush && mem_valid && !mem_ready) |=> $stable(head_q));

endmodule
